// File: rtl/pc_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : pc_seq_pkg                                                       |
// | Brief   : Shared next-PC select encodings and sequencer state encoding.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pc_seq_pkg;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_RA  = 2'b01;
    localparam logic [1:0] NPC_IMM = 2'b10;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

endpackage : pc_seq_pkg

`default_nettype wire

// File: rtl/pc_seq_npc_op_sel.sv
// +----------------------------------------------------------------------------+
// | Module  : npc_op_sel                                                       |
// | Brief   : Priority select of the next-PC adder operation during EXEC.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module npc_op_sel
    import pc_seq_pkg::*;
(
    input  logic       exec_i,
    input  logic       is_jal_i,
    input  logic       is_jalr_i,
    input  logic       is_branch_i,
    input  logic       br_taken_i,
    output logic [1:0] npc_op_o
);

    always_comb begin
        npc_op_o = NPC_PC4;
        if (exec_i) begin
            if (is_jalr_i) begin
                npc_op_o = NPC_RA;
            end else if (is_jal_i) begin
                npc_op_o = NPC_IMM;
            end else if (is_branch_i && br_taken_i) begin
                npc_op_o = NPC_IMM;
            end
        end
    end

endmodule : npc_op_sel

`default_nettype wire

// File: rtl/pc_seq.sv
// +----------------------------------------------------------------------------+
// | Module  : pc_seq                                                           |
// | Brief   : PC sequencer: fetch/exec handshake, PC register, instret counter.|
// |           Define PC_SEQ_TRAP_EN to trap on misaligned control-flow targets.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_seq
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        fetch_req_o,
    input  logic        fetch_ack_i,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic        is_branch_i,
    input  logic        br_taken_i,
    input  logic        stall_i,
    input  logic [31:0] npc_i,
    output logic [1:0]  npc_op_o,
    output logic [31:0] pc_o,
    output logic [31:0] instret_o,
    output logic        trap_o
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic        w_exec;
    logic        w_retire;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RST:     w_next_state = FETCH;
            FETCH:   if (fetch_ack_i) w_next_state = EXEC;
            EXEC:    if (!stall_i)    w_next_state = FETCH;
            default: w_next_state = RST;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_exec   = (r_state == EXEC);
    assign w_retire = w_exec && !stall_i;

    npc_op_sel u_npc_op_sel (
        .exec_i      (w_exec),
        .is_jal_i    (is_jal_i),
        .is_jalr_i   (is_jalr_i),
        .is_branch_i (is_branch_i),
        .br_taken_i  (br_taken_i),
        .npc_op_o    (npc_op_o)
    );

`ifdef PC_SEQ_TRAP_EN
    logic w_misalign;
    logic r_trap;

    assign w_misalign = (npc_i[1:0] != 2'b00);

    // A trapping retire redirects to the vector but does not count as retired.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_instret <= 32'd0;
            r_trap    <= 1'b0;
        end else begin
            r_trap <= w_retire && w_misalign;
            if (w_retire) begin
                if (w_misalign) begin
                    r_pc <= TRAP_VEC;
                end else begin
                    r_pc      <= npc_i;
                    r_instret <= r_instret + 32'd1;
                end
            end
        end
    end

    assign trap_o = r_trap;
`else
    logic w_unused_trap_inputs;

    assign w_unused_trap_inputs = ^{TRAP_VEC, npc_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_pc      <= {npc_i[31:2], 2'b00};
            r_instret <= r_instret + 32'd1;
        end
    end

    assign trap_o = 1'b0;
`endif

    assign fetch_req_o = (r_state == FETCH);
    assign pc_o        = r_pc;
    assign instret_o   = r_instret;

endmodule : pc_seq

`default_nettype wire

// File: tb/tb_pc_seq.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_pc_seq                                                        |
// | Brief   : Self-checking bench for pc_seq against an instruction-level model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_seq;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_req_o;
    logic        fetch_ack_i = 1'b0;
    logic        is_jal_i = 1'b0;
    logic        is_jalr_i = 1'b0;
    logic        is_branch_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] npc_i = 32'd0;
    logic [1:0]  npc_op_o;
    logic [31:0] pc_o;
    logic [31:0] instret_o;
    logic        trap_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_instret;
    logic        exp_trap;

    pc_seq #(
        .RESET_PC (C_RESET_PC),
        .TRAP_VEC (C_TRAP_VEC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .fetch_req_o (fetch_req_o),
        .fetch_ack_i (fetch_ack_i),
        .is_jal_i    (is_jal_i),
        .is_jalr_i   (is_jalr_i),
        .is_branch_i (is_branch_i),
        .br_taken_i  (br_taken_i),
        .stall_i     (stall_i),
        .npc_i       (npc_i),
        .npc_op_o    (npc_op_o),
        .pc_o        (pc_o),
        .instret_o   (instret_o),
        .trap_o      (trap_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Next-PC select from the instruction flags, by the documented priority.
    function automatic logic [1:0] ref_op(input logic jal, input logic jalr,
                                          input logic br, input logic tkn);
        if (jalr)      return 2'b01;
        if (jal)       return 2'b10;
        if (br && tkn) return 2'b10;
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        fetch_ack_i = 1'b1;
        tick();
        #1;
        chk("rst_pc", pc_o, C_RESET_PC);
        chk("rst_instret", instret_o, 32'd0);
        chk("rst_trap", {31'd0, trap_o}, 32'd0);
        chk("rst_req", {31'd0, fetch_req_o}, 32'd0);
        chk("rst_op", {30'd0, npc_op_o}, 32'd0);
        rst_i = 1'b0;
        fetch_ack_i = 1'b0;
        #1;
        chk("rst_release_req", {31'd0, fetch_req_o}, 32'd0);
        exp_pc = C_RESET_PC;
        exp_instret = 32'd0;
        exp_trap = 1'b0;
        tick();
    endtask

    // One instruction: FETCH with ack after ack_wait cycles, EXEC stalled for
    // `stalls` cycles, then retire with target npc. Entered one tick into FETCH.
    task automatic run_instr(input int ack_wait, input int stalls, input logic jal,
                             input logic jalr, input logic br, input logic tkn,
                             input logic [31:0] npc);
        for (int i = 0; i <= ack_wait; i++) begin
            fetch_ack_i = (i == ack_wait);
            {is_jal_i, is_jalr_i, is_branch_i, br_taken_i} = 4'($urandom);
            stall_i = 1'($urandom);
            npc_i = $urandom;
            #1;
            chk("fetch_req", {31'd0, fetch_req_o}, 32'd1);
            chk("fetch_pc", pc_o, exp_pc);
            chk("fetch_op", {30'd0, npc_op_o}, 32'd0);
            chk("fetch_trap", {31'd0, trap_o}, {31'd0, (i == 0) ? exp_trap : 1'b0});
            tick();
        end
        for (int j = 0; j <= stalls; j++) begin
            stall_i = (j < stalls);
            fetch_ack_i = 1'($urandom);
            {is_jal_i, is_jalr_i, is_branch_i, br_taken_i} = {jal, jalr, br, tkn};
            npc_i = npc;
            #1;
            chk("exec_req", {31'd0, fetch_req_o}, 32'd0);
            chk("exec_op", {30'd0, npc_op_o}, {30'd0, ref_op(jal, jalr, br, tkn)});
            chk("exec_pc", pc_o, exp_pc);
            chk("exec_instret", instret_o, exp_instret);
            chk("exec_trap", {31'd0, trap_o}, 32'd0);
            tick();
        end
`ifdef PC_SEQ_TRAP_EN
        if (npc[1:0] != 2'b00) begin
            exp_pc = C_TRAP_VEC;
            exp_trap = 1'b1;
        end else begin
            exp_pc = npc;
            exp_instret = exp_instret + 32'd1;
            exp_trap = 1'b0;
        end
`else
        exp_pc = {npc[31:2], 2'b00};
        exp_instret = exp_instret + 32'd1;
        exp_trap = 1'b0;
`endif
        stall_i = 1'b0;
    endtask

    task automatic run_random(input int n);
        logic [31:0] npc;
        for (int k = 0; k < n; k++) begin
            npc = $urandom;
            if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
            run_instr($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), npc);
        end
    endtask

    initial begin
        do_reset();

        // Straight-line code: pc 0,4,8 then instret 3.
        run_instr(0, 0, 0, 0, 0, 0, exp_pc + 32'd4);
        run_instr(0, 0, 0, 0, 0, 0, exp_pc + 32'd4);
        chk("seq_pc8", pc_o, 32'h8);
        run_instr(0, 0, 0, 0, 0, 0, exp_pc + 32'd4);
        chk("seq_instret3", instret_o, 32'd3);

        run_instr(3, 0, 0, 0, 0, 0, exp_pc + 32'd4);
        run_instr(0, 0, 1, 1, 0, 0, 32'h0000_0200);
        run_instr(0, 0, 0, 0, 1, 0, 32'h0000_0204);
        run_instr(0, 0, 0, 0, 1, 1, 32'h0000_0000);

        run_instr(0, 2, 0, 0, 0, 0, 32'h0000_0040);
        chk("stall_pc40", pc_o, 32'h40);

        run_instr(0, 0, 1, 0, 0, 0, 32'h0000_0042);
`ifdef PC_SEQ_TRAP_EN
        chk("mis_pc", pc_o, 32'h100);
        chk("mis_trap", {31'd0, trap_o}, 32'd1);
`else
        chk("mis_pc", pc_o, 32'h40);
        chk("mis_trap", {31'd0, trap_o}, 32'd0);
`endif
        chk("mis_instret", instret_o, exp_instret);

        run_random(40);

        // Reset mid-stall.
        fetch_ack_i = 1'b1;
        #1;
        chk("pre_stall_req", {31'd0, fetch_req_o}, 32'd1);
        tick();
        stall_i = 1'b1;
        npc_i = 32'h0000_0080;
        #1;
        chk("pre_rst_exec_req", {31'd0, fetch_req_o}, 32'd0);
        stall_i = 1'b0;
        do_reset();
        run_random(10);

        // Reset mid-fetch while the ack arrives in the same cycle.
        #1;
        chk("pre_rst_fetch_req", {31'd0, fetch_req_o}, 32'd1);
        do_reset();
        run_random(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_pc_seq

`default_nettype wire
